// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch slice: bus/word types in common,
// fetch-stage FSM state and decoder bundle in pipes.
package common;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

    localparam u64 PCINIT_DEFAULT = 64'h8000_0000;

    typedef struct packed {
        logic valid;
        u64   addr;
    } ibus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u32   data;
    } ibus_resp_t;

endpackage

package pipes;

    import common::*;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic valid;
        u64   pc;
        u32   raw_instr;
    } fetch_data_t;

endpackage

// File: rtl/fetch_unit_pcselect.sv
// Next fetch address selection for the fetch stage.
// The pc only moves when a request retires or the decoder slot is flushed.
module pcselect
    import common::*;
    import pipes::*;
(
    input  u64           pc,
    input  u64           redirect_pc,
    input  u64           pend_pc,
    input  fetch_state_t state,
    input  logic         flush,
    input  logic         data_ok,
    output u64           next_pc
);

    u64 pc_plus4;

    assign pc_plus4 = pc + 64'd4;

    always_comb begin
        next_pc = pc;
        unique case (state)
            FETCH: begin
                if (data_ok) begin
                    next_pc = flush ? redirect_pc : pc_plus4;
                end
            end
            DRAIN: begin
                if (data_ok) begin
                    next_pc = flush ? redirect_pc : pend_pc;
                end
            end
            HOLD: begin
                if (flush) begin
                    next_pc = redirect_pc;
                end
            end
            default: begin
                next_pc = pc;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage with a one-entry output
// register toward decode and redirect draining of in-flight requests.
module fetch_unit
    import common::*;
    import pipes::*;
#(
    parameter u64 PCINIT = PCINIT_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        stall,
    input  logic        flush,
    input  u64          redirect_pc,
    output fetch_data_t dataF
);

    fetch_state_t state;
    u64           pc;
    u64           pend_pc;
    u64           next_pc;
    logic         data_ok;
    logic         unused_addr_ok;

    assign data_ok        = iresp.data_ok;
    assign unused_addr_ok = iresp.addr_ok;

    // Request is held stable from issue until data_ok since pc only
    // changes on retirement.
    assign ireq.valid = (state != HOLD);
    assign ireq.addr  = pc;

    pcselect u_pcselect (
        .pc          (pc),
        .redirect_pc (redirect_pc),
        .pend_pc     (pend_pc),
        .state       (state),
        .flush       (flush),
        .data_ok     (data_ok),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            pc      <= PCINIT;
            pend_pc <= '0;
            dataF   <= '0;
        end else begin
            pc <= next_pc;
            unique case (state)
                FETCH: begin
                    if (flush && !data_ok) begin
                        pend_pc <= redirect_pc;
                        state   <= DRAIN;
                    end else if (data_ok && !flush) begin
                        dataF.valid     <= 1'b1;
                        dataF.pc        <= pc;
                        dataF.raw_instr <= iresp.data;
                        state           <= HOLD;
                    end
                end
                DRAIN: begin
                    if (data_ok) begin
                        state <= FETCH;
                    end else if (flush) begin
                        pend_pc <= redirect_pc;
                    end
                end
                HOLD: begin
                    if (flush || !stall) begin
                        dataF.valid <= 1'b0;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table plus randomized transaction-level model for fetch_unit.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fetch_unit;

    import common::*;
    import pipes::*;

    logic        clk;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        stall;
    logic        flush;
    u64          redirect_pc;
    fetch_data_t dataF;

    int n_pass;
    int n_total;

    fetch_unit #(.PCINIT(64'h8000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .ireq        (ireq),
        .iresp       (iresp),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .dataF       (dataF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic stl;
        logic fl;
        logic dok;
        u64   redir;
        u32   data;
        logic e_iv;
        u64   e_addr;
        logic e_dv;
        u64   e_pc;
        u32   e_ins;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic stl, input logic fl,
                       input logic dok, input u64 redir, input u32 data,
                       input logic e_iv, input u64 e_addr, input logic e_dv,
                       input u64 e_pc, input u32 e_ins);
        vec_t v;
        v.rst = rst; v.stl = stl; v.fl = fl; v.dok = dok;
        v.redir = redir; v.data = data;
        v.e_iv = e_iv; v.e_addr = e_addr; v.e_dv = e_dv;
        v.e_pc = e_pc; v.e_ins = e_ins;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input u64 act, input u64 exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic drive(input logic rst, input logic stl, input logic fl,
                         input logic dok, input u64 redir, input u32 data,
                         input logic aok);
        reset             = rst;
        stall             = stl;
        flush             = fl;
        redirect_pc       = redir;
        iresp.data_ok     = dok;
        iresp.data        = data;
        iresp.addr_ok     = aok;
    endtask

    task automatic check_out(input string tag, input logic e_iv, input u64 e_addr,
                             input logic e_dv, input u64 e_pc, input u32 e_ins);
        chk({tag, ".ireq.valid"}, 64'(ireq.valid), 64'(e_iv));
        if (e_iv) chk({tag, ".ireq.addr"}, ireq.addr, e_addr);
        chk({tag, ".dataF.valid"}, 64'(dataF.valid), 64'(e_dv));
        if (e_dv) begin
            chk({tag, ".dataF.pc"}, dataF.pc, e_pc);
            chk({tag, ".dataF.raw"}, 64'(dataF.raw_instr), 64'(e_ins));
        end
    endtask

    localparam u64 B = 64'h8000_0000;
    localparam u64 W = 64'hFFFF_FFFF_FFFF_FFFC;

    // transaction-level reference state
    logic m_slot;
    u64   m_pc;
    u32   m_ins;
    u64   m_fpc;
    logic m_rp;
    u64   m_pend;

    initial begin
        n_pass  = 0;
        n_total = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        //   rst stl fl dok redir       data          iv addr  dv pc  ins
        add(0, 0, 0, 0, 0, 0,                         1, B,    0, 0, 0);
        add(0, 0, 0, 1, 0, 32'h13,                    1, B,    0, 0, 0);
        add(0, 0, 0, 0, 0, 0,                         0, 0,    1, B, 32'h13);
        add(0, 0, 0, 0, 0, 0,                         1, B+4,  0, 0, 0);
        add(0, 0, 0, 1, 0, 32'h13,                    1, B+4,  0, 0, 0);
        add(0, 0, 0, 0, 0, 0,                         0, 0,    1, B+4, 32'h13);
        add(0, 0, 0, 0, 0, 0,                         1, B+8,  0, 0, 0);
        add(0, 0, 0, 1, 0, 32'h13,                    1, B+8,  0, 0, 0);
        add(1, 0, 0, 0, 0, 0,                         0, 0,    1, B+8, 32'h13);
        add(0, 0, 0, 1, 0, 32'h0010_0093,             1, B,    0, 0, 0);
        add(0, 1, 0, 0, 0, 0,                         0, 0,    1, B, 32'h0010_0093);
        add(0, 1, 0, 0, 0, 0,                         0, 0,    1, B, 32'h0010_0093);
        add(0, 1, 0, 0, 0, 0,                         0, 0,    1, B, 32'h0010_0093);
        add(0, 0, 0, 0, 0, 0,                         0, 0,    1, B, 32'h0010_0093);
        add(0, 0, 1, 0, 64'h8000_1000, 0,             1, B+4,  0, 0, 0);
        add(0, 0, 0, 0, 0, 0,                         1, B+4,  0, 0, 0);
        add(0, 0, 0, 0, 0, 0,                         1, B+4,  0, 0, 0);
        add(0, 0, 0, 0, 0, 0,                         1, B+4,  0, 0, 0);
        add(0, 0, 0, 1, 0, 32'hDEAD_BEEF,             1, B+4,  0, 0, 0);
        add(0, 0, 1, 1, 64'h8000_2000, 32'h77,        1, 64'h8000_1000, 0, 0, 0);
        add(0, 0, 1, 0, 64'h100, 0,                   1, 64'h8000_2000, 0, 0, 0);
        add(0, 0, 1, 0, 64'h200, 0,                   1, 64'h8000_2000, 0, 0, 0);
        add(0, 0, 0, 1, 0, 32'h55,                    1, 64'h8000_2000, 0, 0, 0);
        add(0, 0, 1, 0, 64'h300, 0,                   1, 64'h200, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0,                         1, 64'h200, 0, 0, 0);
        add(0, 0, 0, 1, 0, 32'h11,                    1, B,    0, 0, 0);
        add(1, 1, 0, 0, 0, 0,                         0, 0,    1, B, 32'h11);
        add(0, 0, 0, 1, 0, 32'h22,                    1, B,    0, 0, 0);
        add(0, 1, 1, 0, W, 0,                         0, 0,    1, B, 32'h22);
        add(0, 0, 0, 1, 0, 32'h33,                    1, W,    0, 0, 0);
        add(0, 0, 0, 0, 0, 0,                         0, 0,    1, W, 32'h33);
        add(0, 0, 0, 0, 0, 0,                         1, 64'h0, 0, 0, 0);

        foreach (vq[i]) begin
            check_out($sformatf("vec%0d", i), vq[i].e_iv, vq[i].e_addr,
                      vq[i].e_dv, vq[i].e_pc, vq[i].e_ins);
            drive(vq[i].rst, vq[i].stl, vq[i].fl, vq[i].dok,
                  vq[i].redir, vq[i].data, 1'b1);
            @(negedge clk);
        end

        // random phase, starting from a fresh reset
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        m_slot = 1'b0; m_pc = '0; m_ins = '0;
        m_fpc = B; m_rp = 1'b0; m_pend = '0;

        for (int n = 0; n < 3000; n++) begin
            logic r, st, fl, dok, aok;
            u64   redir;
            u32   data;
            check_out($sformatf("rnd%0d", n), !m_slot, m_fpc, m_slot, m_pc, m_ins);
            r     = ($urandom_range(0, 63) == 0);
            st    = $urandom_range(0, 1);
            fl    = ($urandom_range(0, 6) == 0);
            dok   = !m_slot && ($urandom_range(0, 2) == 0);
            aok   = $urandom_range(0, 1);
            redir = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                                : {32'($urandom), 32'($urandom)} & ~64'h3;
            data  = $urandom;
            drive(r, st, fl, dok, redir, data, aok);
            if (r) begin
                m_slot = 1'b0; m_fpc = B; m_rp = 1'b0;
            end else if (m_slot) begin
                if (fl) begin
                    m_slot = 1'b0; m_fpc = redir;
                end else if (!st) begin
                    m_slot = 1'b0;
                end
            end else if (dok) begin
                if (fl) begin
                    m_fpc = redir; m_rp = 1'b0;
                end else if (m_rp) begin
                    m_fpc = m_pend; m_rp = 1'b0;
                end else begin
                    m_slot = 1'b1; m_pc = m_fpc; m_ins = data;
                    m_fpc = m_fpc + 64'd4;
                end
            end else if (fl) begin
                m_rp = 1'b1; m_pend = redir;
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 fetch_unit SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: ireq  output  ibus_req_t  instruction bus request (valid, addr).
REQ-005 Port: iresp  input  ibus_resp_t  instruction bus response (addr_ok, data_ok, data[31:0]).
REQ-006 Port: stall  input  1  decode stage cannot accept the output this cycle.
REQ-007 Port: flush  input  1  redirect request from a later stage.
REQ-008 Port: redirect_pc  input  u64  target PC, sampled only when flush=1.
REQ-009 Port: dataF  output  fetch_data_t  registered {valid, pc (u64), raw_instr (u32)} feeding the decoder.
REQ-010 Parameter: PCINIT, default 64'h8000_0000, first fetch address after reset.

Function
REQ-011 FSM SHALL have states FETCH, HOLD and DRAIN.
REQ-012 In FETCH and DRAIN, ireq.valid SHALL be 1 and ireq.addr SHALL equal register pc; in HOLD, ireq.valid SHALL be 0.
REQ-013 Once ireq.valid=1, ireq.valid and ireq.addr SHALL stay constant until the cycle iresp.data_ok=1, including under stall or flush.
REQ-014 FETCH, data_ok=1, flush=0: next cycle dataF={1, pc, iresp.data}, pc<=pc+4, state<=HOLD (latency: data_ok cycle N -> dataF.valid in N+1).
REQ-015 pc+4 SHALL be computed as 64-bit modulo arithmetic (64'hFFFF_FFFF_FFFF_FFFC wraps to 0).
REQ-016 FETCH, flush=1, data_ok=1: response discarded, pc<=redirect_pc, stay in FETCH, dataF.valid stays 0.
REQ-017 FETCH, flush=1, data_ok=0: pend_pc<=redirect_pc, state<=DRAIN.
REQ-018 DRAIN, data_ok=1: response discarded, pc<=pend_pc (or redirect_pc if flush=1 that cycle), state<=FETCH.
REQ-019 DRAIN, flush=1, data_ok=0: pend_pc<=redirect_pc (latest flush wins).
REQ-020 HOLD, stall=1, flush=0: dataF SHALL hold its value unchanged.
REQ-021 HOLD, stall=0, flush=0: output consumed, dataF.valid<=0, state<=FETCH.
REQ-022 HOLD, flush=1 (overrides stall): dataF.valid<=0, pc<=redirect_pc, state<=FETCH.
REQ-023 dataF.valid SHALL be 0 whenever state is FETCH or DRAIN.
REQ-024 iresp.addr_ok SHALL be ignored for control; only data_ok completes a request.

Reset
REQ-025 On reset: state<=FETCH, pc<=PCINIT, pend_pc<=0, dataF<='0.
REQ-026 Reset SHALL override all other inputs in the same cycle, including mid-request or DRAIN; the bus is reset concurrently, and no stale data_ok is expected afterwards.
REQ-027 In the first cycle after reset deasserts, ireq SHALL present {valid=1, addr=PCINIT}.

Structure
REQ-028 fetch_data_t and the FSM state enum SHALL be declared in package pipes.
REQ-029 PCINIT default, u32/u64 and the ibus_req_t/ibus_resp_t types SHALL come from package common.
REQ-030 One combinational sub-module, pcselect, SHALL compute next pc from {pc+4, redirect_pc, pend_pc, flush, state}.
REQ-031 Expected implementation size: 120-400 lines.

Verification
REQ-032 Reset, data_ok every 2nd cycle with data 0x00000013, stall=0 -> dataF pc sequence 0x80000000, 0x80000004, 0x80000008; raw_instr 0x00000013.
REQ-033 data_ok returns 0x00100093 while stall=1 for 3 cycles -> dataF holds {1, 0x80000000, 0x00100093} for 3 cycles, no ireq.valid; released -> next ireq.addr 0x80000004.
REQ-034 flush with redirect_pc=0x80001000 while request to 0x80000000 outstanding, data_ok 4 cycles later -> ireq.addr stays 0x80000000 until data_ok, data discarded, next ireq.addr 0x80001000.
REQ-035 flush and data_ok in the same FETCH cycle, redirect_pc=0x80002000 -> dataF.valid stays 0, next ireq.addr 0x80002000.
REQ-036 Two flushes (0x100, then 0x200) during DRAIN -> after data_ok, ireq.addr=0x200.
REQ-037 Reset asserted in DRAIN, or in HOLD with stall=1 -> next cycle dataF.valid=0, ireq={1, 0x80000000}.
